// File: rtl/pwm_duty_ramp_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : pwm_duty_ramp_ctrl                                         |
// | Description : Soft-start / soft-stop sequencer for the PWM duty          |
// |               setpoint. Latches a clamped target and slews the applied   |
// |               duty toward it at STEP per RAMP_DIV clocks. Fault forces   |
// |               duty to zero at once.                                      |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module pwm_duty_ramp_ctrl #(
   parameter int DUTY_W   = 8,
   parameter int DUTY_MAX = 255,
   parameter int STEP     = 1,
   parameter int RAMP_DIV = 1000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              enable,
   input  logic              fault,
   input  logic              fault_clr,
   input  logic [DUTY_W-1:0] target_duty,
   input  logic              target_valid,
   output logic [DUTY_W-1:0] duty_out,
   output logic              duty_update,
   output logic              at_target,
   output logic              busy,
   output logic              in_fault
);

   localparam int                PRE_W      = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
   localparam logic [DUTY_W-1:0] C_DUTY_MAX = DUTY_W'(DUTY_MAX);
   localparam logic [DUTY_W-1:0] C_STEP     = DUTY_W'(STEP);
   localparam logic [PRE_W-1:0]  C_PRE_LAST = PRE_W'(RAMP_DIV - 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_RAMP  = 3'd1,
      S_HOLD  = 3'd2,
      S_STOP  = 3'd3,
      S_FAULT = 3'd4
   } state_t;

   state_t            state_q, state_nxt;
   logic [DUTY_W-1:0] duty_q, duty_nxt;
   logic [DUTY_W-1:0] target_q, target_nxt;
   logic [PRE_W-1:0]  pre_q, pre_nxt;
   logic              upd_q;

   logic              accept;
   logic [DUTY_W-1:0] clamped;
   logic [DUTY_W-1:0] tgt_eff;
   logic              tick;

   // Move cur toward goal by at most C_STEP; lands exactly on goal, never past it.
   function automatic logic [DUTY_W-1:0] step_toward(input logic [DUTY_W-1:0] cur,
                                                     input logic [DUTY_W-1:0] goal);
      logic [DUTY_W-1:0] diff;
      if (goal > cur) begin
         diff = goal - cur;
         return cur + ((diff < C_STEP) ? diff : C_STEP);
      end else begin
         diff = cur - goal;
         return cur - ((diff < C_STEP) ? diff : C_STEP);
      end
   endfunction

   // Target acceptance (blocked by fault or FAULT state) and ramp tick decode.
   always_comb begin
      accept  = target_valid && !fault && (state_q != S_FAULT);
      clamped = (target_duty > C_DUTY_MAX) ? C_DUTY_MAX : target_duty;
      tgt_eff = accept ? clamped : target_q;
      tick    = (pre_q == C_PRE_LAST);
   end

   // Next-state, next-duty and prescaler logic; fault has top priority.
   always_comb begin
      state_nxt  = state_q;
      duty_nxt   = duty_q;
      target_nxt = tgt_eff;
      pre_nxt    = ((state_q == S_RAMP || state_q == S_STOP) && !tick)
                   ? pre_q + PRE_W'(1) : '0;

      if (fault) begin
         state_nxt = S_FAULT;
         duty_nxt  = '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               duty_nxt = '0;
               if (enable) state_nxt = (tgt_eff != '0) ? S_RAMP : S_HOLD;
            end
            S_RAMP: begin
               if (!enable) begin
                  state_nxt = (duty_q == '0) ? S_IDLE : S_STOP;
               end else if (accept) begin
                  // New goal restarts the prescaler; equal goal settles at once.
                  if (tgt_eff == duty_q) state_nxt = S_HOLD;
               end else if (tick) begin
                  duty_nxt = step_toward(duty_q, target_q);
                  if (duty_nxt == target_q) state_nxt = S_HOLD;
               end
            end
            S_HOLD: begin
               if (!enable)                              state_nxt = (duty_q == '0) ? S_IDLE : S_STOP;
               else if (accept && (tgt_eff != duty_q))  state_nxt = S_RAMP;
            end
            S_STOP: begin
               if (enable) begin
                  // Resume from the present duty, no jump.
                  state_nxt = (tgt_eff == duty_q) ? S_HOLD : S_RAMP;
               end else if (tick && !accept) begin
                  duty_nxt = step_toward(duty_q, '0);
                  if (duty_nxt == '0) state_nxt = S_IDLE;
               end
            end
            S_FAULT: begin
               duty_nxt = '0;
               if (fault_clr) state_nxt = S_IDLE;
            end
            default: begin
               state_nxt = S_IDLE;
               duty_nxt  = '0;
            end
         endcase
      end

      if ((state_nxt != state_q) || accept) pre_nxt = '0;
   end

   // State, duty, target and prescaler registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         duty_q   <= '0;
         target_q <= '0;
         pre_q    <= '0;
         upd_q    <= 1'b0;
      end else begin
         state_q  <= state_nxt;
         duty_q   <= duty_nxt;
         target_q <= target_nxt;
         pre_q    <= pre_nxt;
         upd_q    <= (duty_nxt != duty_q);
      end
   end

   assign duty_out    = duty_q;
   assign duty_update = upd_q;
   assign at_target   = (state_q == S_HOLD);
   assign busy        = (state_q == S_RAMP) || (state_q == S_STOP);
   assign in_fault    = (state_q == S_FAULT);

endmodule
`default_nettype wire
